mtr_pwm_drv: RTL
================

// Module: mtr_pwm_drv
// PURPOSE
//  Consumer end of the PID speed interface. Takes signed 11-bit lft_spd/rght_spd.
//  Produces two channels of sign/magnitude PWM (fwd/rev pin pair per motor) for the H-bridges.
//  Commands are latched at period boundaries so duty changes are glitch-free.
//  A dead-time coast is inserted on every direction reversal.
// PARAMETERS
//  PWM_W     10   magnitude/counter width; PWM period = 2**PWM_W clk cycles
//  DEAD_CYC  32   coast cycles on direction reversal; legal range 1..2**PWM_W-1
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous, active-low reset
//  en         in   1   drive enable (PID moving); 0 forces coast
//  lft_spd    in   11  signed left speed command, two's complement
//  rght_spd   in   11  signed right speed command, two's complement
//  lft_fwd    out  1   left forward PWM, registered
//  lft_rev    out  1   left reverse PWM, registered
//  rght_fwd   out  1   right forward PWM, registered
//  rght_rev   out  1   right reverse PWM, registered
//  prd_strt   out  1   1-clk pulse, registered, high in the cycle cnt==0
// BEHAVIOUR
//  Reset: cnt=0; shadow regs=0; dir=fwd; both channels in IDLE; all outputs 0.
//  Counter
//   - cnt is a PWM_W-bit free-running counter; it wraps 2**PWM_W-1 -> 0.
//   - The counter never stops, including when en=0.
//  Sampling
//   - In the cycle cnt==2**PWM_W-1, both spd inputs load into shadow regs.
//   - Shadow values take effect starting at cnt==0.
//   - Latency: input change to duty change is at most 1 period + 1 clk.
//  Magnitude
//   - mag = |spd|, computed on PWM_W+1 bits.
//   - spd = -1024 saturates to mag = 1023; no wrap to 0.
//   - dir = sign bit. dir updates only when the new mag != 0.
//   - mag = 0 keeps the previous dir, and both outputs stay low.
//  Per-channel FSM (states IDLE, DRIVE, DEAD)
//   - IDLE: outputs 0. Goes to DRIVE at the first cnt==0 with en=1.
//   - DRIVE: the active pin (fwd if dir=0, rev if dir=1) is high when cnt < mag; the other pin is 0.
//   - Reversal: at cnt==0, if the new dir differs from the current dir, go to DEAD.
//     Load dead_cnt = DEAD_CYC-1 and latch the new dir.
//   - DEAD: both pins 0. dead_cnt decrements each clk. At 0, go to DRIVE on the next clk.
//     The duty compare then resumes against the running cnt, so the shortened high time is not compensated.
//   - A period boundary during DEAD with no further reversal: DEAD continues uninterrupted.
//   - Another reversal at a boundary during DEAD: dead_cnt reloads and the newest dir is taken.
//  Enable
//   - en=0 in any state: next clk the FSM is IDLE and all four pins are 0.
//   - dir is retained while en=0.
//   - Re-enable: the first duty starts at the next cnt==0.
//  Invariants
//   - fwd & rev are never both 1 on either channel, in any cycle, including after async reset.
//   - The two channels are fully independent; simultaneous reversals each get their own DEAD.
//  Reset mid-operation: async clear to the reset state; outputs drop immediately (flop clear).
// STRUCTURE
//  Package mtr_pkg holds:
//   - localparam SPD_W=11
//   - typedef enum logic [1:0] {IDLE, DRIVE, DEAD} mtr_st_t
//   - function abs_sat(spd) -> mag
//  Sub-module mtr_pwm_chan, instantiated twice (left, right). It contains:
//   - shadow reg, dir reg, FSM, dead_cnt, registered fwd/rev.
//  Top level holds the shared cnt, the load/strt strobes, and the prd_strt flop.
// TESTING
//  1 Reset, en=1, lft_spd=+256
//    -> from 2nd period, lft_fwd high 256 of 1024 clks; lft_rev=0 throughout.
//  2 rght_spd=-1024
//    -> rght_rev high 1023 clks/period; rght_fwd=0; no zero-duty glitch.
//  3 lft_spd +512 -> -512 mid-period
//    -> old duty completes the period; 32 clks both low from cnt==0; lft_rev high cnt 32..511.
//  4 spd +300 -> 0 -> -300, one period each
//    -> the zero period keeps dir=fwd; the -300 period starts with DEAD then rev.
//  5 en dropped during DEAD, re-asserted 10 clks later
//    -> pins 0 next clk; IDLE until next cnt==0; duty resumes with the latched dir.
//  6 rst_n asserted mid-pulse
//    -> all outputs 0 that instant; every cycle asserts !(fwd&rev) on both channels.

Source files
------------

// File: rtl/mtr_pkg.sv
// Shared types and helpers for the motor PWM driver.
// Speed width, channel state encoding and magnitude saturation.
package mtr_pkg;

    localparam int SPD_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DEAD
    } mtr_st_t;

    // -1024 would wrap to 0 on negation; clamp it to full scale instead
    function automatic logic [SPD_W-1:0] abs_sat(input logic [SPD_W-1:0] spd);
        logic [SPD_W-1:0] mag;
        mag = spd[SPD_W-1] ? (~spd + SPD_W'(1)) : spd;
        if (mag[SPD_W-1]) begin
            mag = {1'b0, {(SPD_W-1){1'b1}}};
        end
        return mag;
    endfunction

endpackage

// File: rtl/mtr_pwm_chan.sv
// One sign/magnitude PWM channel: shadow speed, direction,
// IDLE/DRIVE/DEAD state machine and registered fwd/rev pins.
module mtr_pwm_chan
    import mtr_pkg::*;
#(
    parameter int PWM_W    = 10,
    parameter int DEAD_CYC = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             bnd,
    input  logic [PWM_W-1:0] cnt_nxt,
    input  logic [SPD_W-1:0] spd,
    output logic             fwd,
    output logic             rev
);

    localparam logic [PWM_W-1:0] DEAD_LD = PWM_W'(DEAD_CYC - 1);

    mtr_st_t          st_q;
    mtr_st_t          st_d;
    logic [SPD_W-1:0] shd_q;
    logic             dir_q;
    logic             dir_d;
    logic [PWM_W-1:0] dead_q;
    logic [PWM_W-1:0] dead_d;
    logic [SPD_W-1:0] mag_new;
    logic [SPD_W-1:0] mag_use;
    logic             dir_new;
    logic             rvs;
    logic             hi;
    logic             drv;

    // Outputs are computed for the upcoming cycle, so at a boundary the
    // value being latched is used directly; it equals the next shadow.
    assign mag_new = abs_sat(spd);
    assign dir_new = spd[SPD_W-1];
    assign mag_use = bnd ? mag_new : abs_sat(shd_q);
    assign rvs     = bnd && (mag_new != '0) && (dir_new != dir_q);
    assign hi      = 32'(cnt_nxt) < 32'(mag_use);

    always_comb begin
        st_d   = st_q;
        dir_d  = dir_q;
        dead_d = dead_q;
        if (!en) begin
            st_d = IDLE;
        end else begin
            unique case (st_q)
                IDLE: begin
                    if (bnd) begin
                        st_d = DRIVE;
                        if (mag_new != '0) dir_d = dir_new;
                    end
                end
                DRIVE: begin
                    if (rvs) begin
                        st_d   = DEAD;
                        dead_d = DEAD_LD;
                        dir_d  = dir_new;
                    end
                end
                DEAD: begin
                    if (rvs) begin
                        dead_d = DEAD_LD;
                        dir_d  = dir_new;
                    end else if (dead_q == '0) begin
                        st_d = DRIVE;
                    end else begin
                        dead_d = dead_q - PWM_W'(1);
                    end
                end
                default: st_d = IDLE;
            endcase
        end
    end

    assign drv = (st_d == DRIVE) && hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            shd_q  <= '0;
            dir_q  <= 1'b0;
            dead_q <= '0;
            fwd    <= 1'b0;
            rev    <= 1'b0;
        end else begin
            st_q   <= st_d;
            dir_q  <= dir_d;
            dead_q <= dead_d;
            fwd    <= drv && !dir_d;
            rev    <= drv && dir_d;
            if (bnd) shd_q <= spd;
        end
    end

endmodule

// File: rtl/mtr_pwm_drv.sv
// Dual-channel H-bridge PWM driver: shared period counter,
// boundary strobe, period-start pulse and two independent channels.
module mtr_pwm_drv
    import mtr_pkg::*;
#(
    parameter int PWM_W    = 10,
    parameter int DEAD_CYC = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SPD_W-1:0] lft_spd,
    input  logic [SPD_W-1:0] rght_spd,
    output logic             lft_fwd,
    output logic             lft_rev,
    output logic             rght_fwd,
    output logic             rght_rev,
    output logic             prd_strt
);

    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] cnt_nxt;
    logic             bnd;

    // bnd marks the last cycle of a period: shadow load and FSM boundary
    assign cnt_nxt = cnt + PWM_W'(1);
    assign bnd     = (cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            prd_strt <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            prd_strt <= bnd;
        end
    end

    mtr_pwm_chan #(
        .PWM_W    (PWM_W),
        .DEAD_CYC (DEAD_CYC)
    ) u_lft (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .bnd     (bnd),
        .cnt_nxt (cnt_nxt),
        .spd     (lft_spd),
        .fwd     (lft_fwd),
        .rev     (lft_rev)
    );

    mtr_pwm_chan #(
        .PWM_W    (PWM_W),
        .DEAD_CYC (DEAD_CYC)
    ) u_rght (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .bnd     (bnd),
        .cnt_nxt (cnt_nxt),
        .spd     (rght_spd),
        .fwd     (rght_fwd),
        .rev     (rght_rev)
    );

endmodule
